store_buffer_queue: RTL and testbench

Parametrised store buffer for the memory stage, sitting between the pipeline's store/load requests and the data cache. Retires stores into a DEPTH-entry FIFO, drains them to the cache in program order through a valid/ready handshake, and forwards store data to younger loads on a same-cycle lookup. Supports word and byte stores, and signals a stall when forwarding is only partially possible. Successor to the fixed single-entry store buffer.

---
 rtl/store_buffer_queue_if.sv | 64 ++++++
 rtl/store_buffer_queue.sv | 173 +++++++++++++++++
 tb/tb_store_buffer_queue.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_queue_if.sv
// store_buffer_queue_if
// Groups the store buffer's handshake and lookup signals into a single bundle.
//
// Parameters:
//   DEPTH   number of store buffer entries (sets the width of count)
//   ADDR_W  address width in bits
//   DATA_W  data width in bits (32 for byte-lane logic)
//
// Signal groups:
//   enq_*    store requests from the memory stage (enq_ready returned)
//   ld_*     same-cycle load lookup and its forwarding result
//   drain_*  head entry presented to the data cache (drain_ready returned)
//   count    number of occupied entries
//
// Modports:
//   master  pipeline/cache side: drives requests, observes results
//   slave   store buffer side: observes requests, drives results
interface store_buffer_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                     enq_valid;
    logic [ADDR_W-1:0]        enq_addr;
    logic [DATA_W-1:0]        enq_data;
    logic                     enq_byte;
    logic                     enq_ready;

    logic                     ld_valid;
    logic [ADDR_W-1:0]        ld_addr;
    logic                     ld_byte;
    logic                     ld_hit;
    logic [DATA_W-1:0]        ld_data;
    logic                     ld_miss;
    logic                     ld_stall;

    logic                     drain_valid;
    logic [ADDR_W-1:0]        drain_addr;
    logic [DATA_W-1:0]        drain_data;
    logic                     drain_byte;
    logic                     drain_ready;

    logic [$clog2(DEPTH):0]   count;

    modport master (
        output enq_valid, enq_addr, enq_data, enq_byte,
        output ld_valid, ld_addr, ld_byte,
        output drain_ready,
        input  enq_ready,
        input  ld_hit, ld_data, ld_miss, ld_stall,
        input  drain_valid, drain_addr, drain_data, drain_byte,
        input  count
    );

    modport slave (
        input  enq_valid, enq_addr, enq_data, enq_byte,
        input  ld_valid, ld_addr, ld_byte,
        input  drain_ready,
        output enq_ready,
        output ld_hit, ld_data, ld_miss, ld_stall,
        output drain_valid, drain_addr, drain_data, drain_byte,
        output count
    );
endinterface

// File: rtl/store_buffer_queue.sv
// store_buffer_queue
// Memory-stage store buffer. Accepted stores sit in a DEPTH-entry circular
// FIFO and drain to the data cache in program order over a valid/ready
// handshake. Loads look up the buffer in the same cycle and either receive
// forwarded data, miss (go to the cache), or stall on a partial overlap.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset; discards all buffered stores
//   sb   store_buffer_queue_if.slave (enq_*, ld_*, drain_*, count)
//
// Build option:
//   SB_COALESCE_EN  when defined, a word store to the same word as the
//                   youngest word entry overwrites that entry's data
//                   instead of allocating; enq_ready may then be 1 when
//                   full and depends combinationally on enq_addr/enq_byte.
module store_buffer_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic                clk,
    input logic                rst,
    store_buffer_queue_if.slave sb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] entryAddr  [DEPTH];
    logic [DATA_W-1:0] entryData  [DEPTH];
    logic              entryByte  [DEPTH];
    logic              entryValid [DEPTH];

    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic [CNT_W-1:0]  countReg;

    logic              full;
    logic              empty;
    logic              enqReady;
    logic              doPop;
    logic              doPush;
    logic              coalesceOk;
    logic              doCoalesce;

    logic              matchFound;
    logic [PTR_W-1:0]  matchIdx;
    logic [PTR_W-1:0]  scanIdx;
    logic [7:0]        laneByte;

    assign full  = (countReg == FULL_CNT);
    assign empty = (countReg == '0);
    assign doPop = !empty && sb.drain_ready;

`ifdef SB_COALESCE_EN
    logic [PTR_W-1:0] youngPtr;

    // The youngest entry sits just behind the tail. Coalescing into it is
    // refused when it is also the head leaving this cycle, otherwise the
    // new data would vanish with the pop.
    assign youngPtr   = tailPtr - PTR_W'(1);
    assign coalesceOk = !sb.enq_byte && !empty &&
                        entryValid[youngPtr] && !entryByte[youngPtr] &&
                        (entryAddr[youngPtr][ADDR_W-1:2] == sb.enq_addr[ADDR_W-1:2]) &&
                        !((countReg == CNT_W'(1)) && doPop);
`else
    assign coalesceOk = 1'b0;
`endif

    // A full buffer refuses stores even when the head drains this cycle;
    // this keeps enq_ready independent of drain_ready.
    assign enqReady   = !full || coalesceOk;
    assign doCoalesce = sb.enq_valid && coalesceOk;
    assign doPush     = sb.enq_valid && enqReady && !doCoalesce;

    assign sb.enq_ready   = enqReady;
    assign sb.count       = countReg;
    assign sb.drain_valid = !empty;
    assign sb.drain_addr  = entryAddr[headPtr];
    assign sb.drain_data  = entryData[headPtr];
    assign sb.drain_byte  = entryByte[headPtr];

    // Scan occupied entries oldest to youngest so that the last hit wins,
    // leaving matchIdx on the youngest store to the load's word.
    always_comb begin
        matchFound = 1'b0;
        matchIdx   = '0;
        scanIdx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scanIdx = headPtr + PTR_W'(i);
            if ((CNT_W'(i) < countReg) && entryValid[scanIdx] &&
                (entryAddr[scanIdx][ADDR_W-1:2] == sb.ld_addr[ADDR_W-1:2])) begin
                matchFound = 1'b1;
                matchIdx   = scanIdx;
            end
        end
    end

    // Resolve the youngest match into hit, miss or stall. A byte store can
    // only satisfy a byte load to exactly the same byte; anything else
    // needs bytes the buffer does not hold, so the load must wait.
    always_comb begin
        sb.ld_hit   = 1'b0;
        sb.ld_miss  = 1'b0;
        sb.ld_stall = 1'b0;
        sb.ld_data  = '0;
        laneByte    = '0;
        case (sb.ld_addr[1:0])
            2'd0:    laneByte = entryData[matchIdx][7:0];
            2'd1:    laneByte = entryData[matchIdx][15:8];
            2'd2:    laneByte = entryData[matchIdx][23:16];
            default: laneByte = entryData[matchIdx][31:24];
        endcase
        if (sb.ld_valid) begin
            if (!matchFound) begin
                sb.ld_miss = 1'b1;
            end else if (!entryByte[matchIdx]) begin
                sb.ld_hit = 1'b1;
                if (sb.ld_byte) begin
                    sb.ld_data = {{(DATA_W-8){1'b0}}, laneByte};
                end else begin
                    sb.ld_data = entryData[matchIdx];
                end
            end else if (sb.ld_byte &&
                         (entryAddr[matchIdx][1:0] == sb.ld_addr[1:0])) begin
                sb.ld_hit  = 1'b1;
                sb.ld_data = {{(DATA_W-8){1'b0}}, entryData[matchIdx][7:0]};
            end else begin
                sb.ld_stall = 1'b1;
            end
        end
    end

    // FIFO state. Pointers wrap naturally because DEPTH is a power of two.
    // Push and pop never target the same slot: tail equals head only when
    // the buffer is empty (no pop) or full (no push).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            countReg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entryAddr[i]  <= '0;
                entryData[i]  <= '0;
                entryByte[i]  <= 1'b0;
                entryValid[i] <= 1'b0;
            end
        end else begin
            if (doPush) begin
                entryAddr[tailPtr]  <= sb.enq_addr;
                entryData[tailPtr]  <= sb.enq_data;
                entryByte[tailPtr]  <= sb.enq_byte;
                entryValid[tailPtr] <= 1'b1;
                tailPtr             <= tailPtr + PTR_W'(1);
            end
`ifdef SB_COALESCE_EN
            if (doCoalesce) begin
                entryData[youngPtr] <= sb.enq_data;
            end
`endif
            if (doPop) begin
                entryValid[headPtr] <= 1'b0;
                headPtr             <= headPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + CNT_W'(1);
                2'b01:   countReg <= countReg - CNT_W'(1);
                default: countReg <= countReg;
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer_queue.sv
// tb_store_buffer_queue
// Self-checking bench for store_buffer_queue (DEPTH = 4, 32-bit address
// and data). A vector table covers forwarding priority, byte extraction,
// partial overlap and full/drain behaviour; hand sequences cover fill and
// drain order, wrap-around with simultaneous push/pop, asynchronous reset
// mid-drain and, with SB_COALESCE_EN, coalescing while full; a random phase
// compares every cycle against a queue-based reference model.
module tb_store_buffer_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic clk;
    logic rst;
    int   testsRun  = 0;
    int   failCount = 0;

    store_buffer_queue_if #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) sb ();

    store_buffer_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        enqValid;
        logic [31:0] enqAddr;
        logic [31:0] enqData;
        logic        enqByte;
        logic        ldValid;
        logic [31:0] ldAddr;
        logic        ldByte;
        logic        drainReady;
        logic        expEnqReady;
        logic        expHit;
        logic [31:0] expData;
        logic        expMiss;
        logic        expStall;
        logic        expDrainValid;
        logic [31:0] expDrainAddr;
        int          expCount;
    } vecT;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        isByte;
    } entryT;

    vecT   vecs [14];
    entryT modelQ [$];

    function automatic vecT mk(input logic ev, input logic [31:0] ea, input logic [31:0] ed,
                               input logic eb, input logic lv, input logic [31:0] la,
                               input logic lb, input logic dr, input logic rdy, input logic hit,
                               input logic [31:0] dat, input logic miss, input logic stall,
                               input logic dv, input logic [31:0] da, input int cnt);
        vecT v;
        v.enqValid = ev;  v.enqAddr = ea;  v.enqData = ed;  v.enqByte = eb;
        v.ldValid = lv;   v.ldAddr = la;   v.ldByte = lb;   v.drainReady = dr;
        v.expEnqReady = rdy; v.expHit = hit; v.expData = dat; v.expMiss = miss;
        v.expStall = stall;  v.expDrainValid = dv; v.expDrainAddr = da; v.expCount = cnt;
        return v;
    endfunction

    task automatic applyStimulus(input logic ev, input logic [31:0] ea, input logic [31:0] ed,
                                 input logic eb, input logic lv, input logic [31:0] la,
                                 input logic lb, input logic dr);
        sb.enq_valid   = ev;
        sb.enq_addr    = ea;
        sb.enq_data    = ed;
        sb.enq_byte    = eb;
        sb.ld_valid    = lv;
        sb.ld_addr     = la;
        sb.ld_byte     = lb;
        sb.drain_ready = dr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        @(negedge clk);
        rst = 1'b1;
        modelQ.delete();
    endtask

    // Reference lookup: walk the queue from youngest to oldest.
    task automatic modelLookup(input logic [31:0] la, input logic lb, output logic hit,
                               output logic miss, output logic stall, output logic [31:0] data);
        entryT e;
        bit    found;
        hit = 1'b0; miss = 1'b0; stall = 1'b0; data = 32'h0; found = 1'b0;
        e = '{addr: 32'h0, data: 32'h0, isByte: 1'b0};
        for (int i = modelQ.size() - 1; i >= 0; i--) begin
            if (!found && modelQ[i].addr[31:2] == la[31:2]) begin
                found = 1'b1;
                e = modelQ[i];
            end
        end
        if (!found) begin
            miss = 1'b1;
        end else if (!e.isByte) begin
            hit  = 1'b1;
            data = lb ? ((e.data >> (8 * la[1:0])) & 32'hFF) : e.data;
        end else if (lb && e.addr == la) begin
            hit  = 1'b1;
            data = {24'h0, e.data[7:0]};
        end else begin
            stall = 1'b1;
        end
    endtask

    logic        rEv, rEb, rLv, rLb, rDr;
    logic [31:0] rEa, rEd, rLa;
    logic        mHit, mMiss, mStall, mRdy, mCoal, mPop;
    logic [31:0] mData;
    entryT       newEntry;

    initial begin
        vecs[0]  = mk(1'b0, 32'h00, 32'h0,        1'b0, 1'b1, 32'h20, 1'b0, 1'b0,
                      1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00, 0);
        vecs[1]  = mk(1'b1, 32'h20, 32'h11111111, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0,
                      1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h00, 0);
        vecs[2]  = mk(1'b1, 32'h61, 32'h5A,       1'b1, 1'b1, 32'h20, 1'b0, 1'b0,
                      1'b1, 1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 32'h20, 1);
        vecs[3]  = mk(1'b1, 32'h20, 32'h22222222, 1'b0, 1'b1, 32'h60, 1'b0, 1'b0,
                      1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h20, 2);
        vecs[4]  = mk(1'b0, 32'h00, 32'h0,        1'b0, 1'b1, 32'h20, 1'b0, 1'b0,
                      1'b1, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, 32'h20, 3);
        vecs[5]  = mk(1'b0, 32'h00, 32'h0,        1'b0, 1'b1, 32'h61, 1'b1, 1'b0,
                      1'b1, 1'b1, 32'h5A,       1'b0, 1'b0, 1'b1, 32'h20, 3);
        vecs[6]  = mk(1'b0, 32'h00, 32'h0,        1'b0, 1'b1, 32'h62, 1'b1, 1'b0,
                      1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h20, 3);
        vecs[7]  = mk(1'b1, 32'h40, 32'hAABBCCDD, 1'b0, 1'b1, 32'h60, 1'b1, 1'b0,
                      1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h20, 3);
        vecs[8]  = mk(1'b1, 32'h50, 32'h99,       1'b0, 1'b1, 32'h42, 1'b1, 1'b0,
                      1'b0, 1'b1, 32'hBB,       1'b0, 1'b0, 1'b1, 32'h20, 4);
        vecs[9]  = mk(1'b1, 32'h54, 32'h98,       1'b0, 1'b1, 32'h43, 1'b1, 1'b1,
                      1'b0, 1'b1, 32'hAA,       1'b0, 1'b0, 1'b1, 32'h20, 4);
        vecs[10] = mk(1'b0, 32'h00, 32'h0,        1'b0, 1'b1, 32'h20, 1'b0, 1'b1,
                      1'b1, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, 32'h61, 3);
        vecs[11] = mk(1'b0, 32'h00, 32'h0,        1'b0, 1'b1, 32'h60, 1'b0, 1'b0,
                      1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h20, 2);
        vecs[12] = mk(1'b0, 32'h00, 32'h0,        1'b0, 1'b1, 32'h41, 1'b1, 1'b0,
                      1'b1, 1'b1, 32'hCC,       1'b0, 1'b0, 1'b1, 32'h20, 2);
        vecs[13] = mk(1'b0, 32'h00, 32'h0,        1'b0, 1'b0, 32'h40, 1'b0, 1'b0,
                      1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h20, 2);

        // Reset state with a load presented: it must miss.
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst.count",      32'(sb.count),       32'd0);
        checkOutput("rst.enqReady",   32'(sb.enq_ready),   32'd1);
        checkOutput("rst.drainValid", 32'(sb.drain_valid), 32'd0);
        checkOutput("rst.drainAddr",  sb.drain_addr,       32'h0);
        checkOutput("rst.drainData",  sb.drain_data,       32'h0);
        checkOutput("rst.drainByte",  32'(sb.drain_byte),  32'd0);
        checkOutput("rst.ldMiss",     32'(sb.ld_miss),     32'd1);
        checkOutput("rst.ldHit",      32'(sb.ld_hit),      32'd0);
        checkOutput("rst.ldStall",    32'(sb.ld_stall),    32'd0);
        rst = 1'b1;

        // Vector table, one row per cycle.
        for (int r = 0; r < 14; r++) begin
            @(negedge clk);
            applyStimulus(vecs[r].enqValid, vecs[r].enqAddr, vecs[r].enqData, vecs[r].enqByte,
                          vecs[r].ldValid, vecs[r].ldAddr, vecs[r].ldByte, vecs[r].drainReady);
            #1;
            checkOutput($sformatf("vec%0d.enqReady", r),   32'(sb.enq_ready),   32'(vecs[r].expEnqReady));
            checkOutput($sformatf("vec%0d.ldHit", r),      32'(sb.ld_hit),      32'(vecs[r].expHit));
            checkOutput($sformatf("vec%0d.ldMiss", r),     32'(sb.ld_miss),     32'(vecs[r].expMiss));
            checkOutput($sformatf("vec%0d.ldStall", r),    32'(sb.ld_stall),    32'(vecs[r].expStall));
            if (vecs[r].expHit)
                checkOutput($sformatf("vec%0d.ldData", r), sb.ld_data,          vecs[r].expData);
            checkOutput($sformatf("vec%0d.drainValid", r), 32'(sb.drain_valid), 32'(vecs[r].expDrainValid));
            checkOutput($sformatf("vec%0d.drainAddr", r),  sb.drain_addr,       vecs[r].expDrainAddr);
            checkOutput($sformatf("vec%0d.count", r),      32'(sb.count),       32'(vecs[r].expCount));
        end

        // Fill and drain in order.
        doReset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            applyStimulus(1'b1, 32'h10 + 32'(4 * k), 32'h1000 + 32'(k), 1'b0,
                          1'b0, 32'h0, 1'b0, 1'b0);
        end
        @(negedge clk);
        idle();
        #1;
        checkOutput("fill.count",    32'(sb.count),     32'd4);
        checkOutput("fill.enqReady", 32'(sb.enq_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            #1;
            checkOutput($sformatf("drain%0d.addr", k),  sb.drain_addr,       32'h10 + 32'(4 * k));
            checkOutput($sformatf("drain%0d.data", k),  sb.drain_data,       32'h1000 + 32'(k));
            checkOutput($sformatf("drain%0d.valid", k), 32'(sb.drain_valid), 32'd1);
        end
        @(negedge clk);
        idle();
        #1;
        checkOutput("drained.count", 32'(sb.count),       32'd0);
        checkOutput("drained.valid", 32'(sb.drain_valid), 32'd0);

        // Hold three entries while pushing and popping every cycle.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            applyStimulus(1'b1, 32'h100 + 32'(4 * k), 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            applyStimulus(1'b1, 32'h100 + 32'(4 * (c + 3)), 32'h0, 1'b0,
                          1'b0, 32'h0, 1'b0, 1'b1);
            #1;
            checkOutput($sformatf("wrap%0d.count", c), 32'(sb.count),  32'd3);
            checkOutput($sformatf("wrap%0d.addr", c),  sb.drain_addr,  32'h100 + 32'(4 * c));
        end

        // Asynchronous reset while draining three entries.
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h12C, 1'b0, 1'b1);
        #1;
        checkOutput("preRst.count", 32'(sb.count), 32'd3);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("midRst.count",      32'(sb.count),       32'd0);
        checkOutput("midRst.drainValid", 32'(sb.drain_valid), 32'd0);
        checkOutput("midRst.drainAddr",  sb.drain_addr,       32'h0);
        checkOutput("midRst.enqReady",   32'(sb.enq_ready),   32'd1);
        checkOutput("midRst.ldMiss",     32'(sb.ld_miss),     32'd1);
        checkOutput("midRst.ldHit",      32'(sb.ld_hit),      32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("postRst.count", 32'(sb.count), 32'd0);
        modelQ.delete();

`ifdef SB_COALESCE_EN
        // Coalescing into the youngest word entry while full.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            applyStimulus(1'b1, 32'h74 + 32'(4 * k), 32'h700 + 32'(k), 1'b0,
                          1'b0, 32'h0, 1'b0, 1'b0);
        end
        @(negedge clk);
        applyStimulus(1'b1, 32'h84, 32'hDEAD0000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("coal.noMatchReady", 32'(sb.enq_ready), 32'd0);
        applyStimulus(1'b1, 32'h80, 32'hCAFEF00D, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
        #1;
        checkOutput("coal.enqReady", 32'(sb.enq_ready), 32'd1);
        checkOutput("coal.oldData",  sb.ld_data,        32'h703);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
        #1;
        checkOutput("coal.count",   32'(sb.count),  32'd4);
        checkOutput("coal.ldHit",   32'(sb.ld_hit), 32'd1);
        checkOutput("coal.newData", sb.ld_data,     32'hCAFEF00D);
`endif

        // Random traffic against the reference model.
        doReset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rEv = 1'($urandom_range(0, 1));
            rEb = 1'($urandom_range(0, 2) == 0);
            rEa = 32'h200 + 32'($urandom_range(0, 15));
            rEd = $urandom;
            rLv = 1'($urandom_range(0, 3) != 0);
            rLb = 1'($urandom_range(0, 1));
            rLa = 32'h200 + 32'($urandom_range(0, 15));
            rDr = 1'($urandom_range(0, 2) == 0);
            @(negedge clk);
            applyStimulus(rEv, rEa, rEd, rEb, rLv, rLa, rLb, rDr);
            #1;
            mPop  = (modelQ.size() > 0) && rDr;
            mCoal = 1'b0;
`ifdef SB_COALESCE_EN
            if (!rEb && modelQ.size() > 0 && !modelQ[modelQ.size()-1].isByte &&
                modelQ[modelQ.size()-1].addr[31:2] == rEa[31:2] &&
                !(modelQ.size() == 1 && mPop))
                mCoal = 1'b1;
`endif
            mRdy = (modelQ.size() != DEPTH) || mCoal;
            modelLookup(rLa, rLb, mHit, mMiss, mStall, mData);
            if (!rLv) begin
                mHit = 1'b0; mMiss = 1'b0; mStall = 1'b0;
            end
            checkOutput("rnd.enqReady",   32'(sb.enq_ready),   32'(mRdy));
            checkOutput("rnd.ldHit",      32'(sb.ld_hit),      32'(mHit));
            checkOutput("rnd.ldMiss",     32'(sb.ld_miss),     32'(mMiss));
            checkOutput("rnd.ldStall",    32'(sb.ld_stall),    32'(mStall));
            if (mHit)
                checkOutput("rnd.ldData", sb.ld_data, mData);
            checkOutput("rnd.count",      32'(sb.count),       32'(modelQ.size()));
            checkOutput("rnd.drainValid", 32'(sb.drain_valid), 32'(modelQ.size() > 0));
            if (modelQ.size() > 0) begin
                checkOutput("rnd.drainAddr", sb.drain_addr,      modelQ[0].addr);
                checkOutput("rnd.drainByte", 32'(sb.drain_byte), 32'(modelQ[0].isByte));
                if (modelQ[0].isByte)
                    checkOutput("rnd.drainData", {24'h0, sb.drain_data[7:0]},
                                {24'h0, modelQ[0].data[7:0]});
                else
                    checkOutput("rnd.drainData", sb.drain_data, modelQ[0].data);
            end
            @(posedge clk);
            if (rEv && mCoal)
                modelQ[modelQ.size()-1].data = rEd;
            if (mPop)
                void'(modelQ.pop_front());
            if (rEv && mRdy && !mCoal) begin
                newEntry.addr   = rEa;
                newEntry.data   = rEd;
                newEntry.isByte = rEb;
                modelQ.push_back(newEntry);
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end
endmodule
